// File: rtl/team_06_delay_line_ctrl_if.sv
// rtl/team_06_delay_line_ctrl_if.sv - SRAM request/response port of the echo delay-line sequencer
interface team_06_delay_line_ctrl_if #(
  parameter int ADDR_W = 13
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/team_06_delay_line_ctrl.sv
// rtl/team_06_delay_line_ctrl.sv - circular delay-line writer/reader for the echo path
// Optional macro TEAM_06_FILL_GUARD_EN: skip reads that would reach locations not yet written.
module team_06_delay_line_ctrl #(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [7:0]  save_audio,
  input  logic        search,
  input  logic [12:0] offset,
  output logic [7:0]  past_output,
  output logic        past_valid,
  output logic        busy,
  output logic        overrun,
  team_06_delay_line_ctrl_if.master mem
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] offset_q;
  logic [7:0]        sample_q;
  logic              search_q;
  logic              guard_ok;

  logic              req_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        wdata_d;

`ifdef TEAM_06_FILL_GUARD_EN
  // fill_q is the occupancy before the current write, since it only updates on the write ack
  logic [ADDR_W:0] fill_q;

  assign guard_ok = ({1'b0, offset_q} <= fill_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
    end else if (state_q == WRITE && mem.mem_ack && fill_q != (ADDR_W+1)'(DEPTH)) begin
      fill_q <= fill_q + 1'b1;
    end
  end
`else
  assign guard_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_valid) state_d = WRITE;
      WRITE:   if (mem.mem_ack) state_d = (search_q && guard_ok) ? READ : DONE;
      READ:    if (mem.mem_ack) state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered, so they are derived from the state being entered
    req_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    case (state_d)
      WRITE: begin
        req_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = (state_q == IDLE) ? wr_ptr_q : wr_addr_q;
        wdata_d = (state_q == IDLE) ? save_audio : sample_q;
      end
      READ: begin
        req_d  = 1'b1;
        addr_d = wr_addr_q - offset_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      wr_addr_q     <= '0;
      offset_q      <= '0;
      sample_q      <= '0;
      search_q      <= 1'b0;
      past_output   <= '0;
      past_valid    <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      state_q       <= state_d;
      busy          <= (state_d != IDLE);
      past_valid    <= (state_d == DONE);
      overrun       <= sample_valid && (state_q != IDLE);
      mem.mem_req   <= req_d;
      mem.mem_we    <= we_d;
      mem.mem_addr  <= addr_d;
      mem.mem_wdata <= wdata_d;

      if (state_q == IDLE && sample_valid) begin
        sample_q  <= save_audio;
        search_q  <= search;
        offset_q  <= (32'(offset) > DEPTH - 1) ? ADDR_W'(DEPTH - 1) : ADDR_W'(offset);
        wr_addr_q <= wr_ptr_q;
      end

      if (state_q == WRITE && mem.mem_ack) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (state_d == DONE) past_output <= '0;
      end

      if (state_q == READ && mem.mem_ack) begin
        past_output <= mem.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_team_06_delay_line_ctrl.sv
// tb/tb_team_06_delay_line_ctrl.sv - scoreboard bench for the echo delay-line sequencer
module tb_team_06_delay_line_ctrl;

  localparam int DEPTH = 8192;

  typedef struct {
    logic       we;
    int         addr;
    logic [7:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [7:0]  save_audio;
  logic        search;
  logic [12:0] offset;
  logic [7:0]  past_output;
  logic        past_valid;
  logic        busy;
  logic        overrun;

  team_06_delay_line_ctrl_if #(.ADDR_W(13)) bus ();

  team_06_delay_line_ctrl #(.DEPTH(DEPTH), .ADDR_W(13)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .save_audio   (save_audio),
    .search       (search),
    .offset       (offset),
    .past_output  (past_output),
    .past_valid   (past_valid),
    .busy         (busy),
    .overrun      (overrun),
    .mem          (bus)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         issue_cyc = 0;
  int         pv_cyc = 0;
  int         wcount = 0;
  int         ovr_seen = 0;
  int         ovr_exp = 0;
  int         wait_target = 0;
  bit         rand_wait = 0;
  int         last_rd_addr = -1;
  logic [7:0] sram [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  acc_t       exp_acc [$];
  logic [7:0] exp_past [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s", nm);
  endtask

  always @(posedge clk) cyc++;

  // SRAM model: configurable wait states, checks each completed access against the scoreboard
  int          wcnt = 0;
  int          cur_wait = 0;
  logic [21:0] snap;
  always @(negedge clk) begin
    acc_t a;
    if (rst) begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
    end else if (bus.mem_req) begin
      if (wcnt == 0) begin
        snap = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
        cur_wait = rand_wait ? int'($urandom_range(0, 2)) : wait_target;
      end else begin
        chk("req_stable", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'(snap));
        chk("busy_in_wait", 32'(busy), 32'd1);
      end
      if (wcnt == cur_wait) begin
        bus.mem_ack = 1'b1;
        if (exp_acc.size() == 0) begin
          fail("unexpected_access");
        end else begin
          a = exp_acc.pop_front();
          chk("acc_we", 32'(bus.mem_we), 32'(a.we));
          chk("acc_addr", 32'(bus.mem_addr), a.addr);
          if (a.we) chk("acc_wdata", 32'(bus.mem_wdata), 32'(a.data));
        end
        if (bus.mem_we) begin
          sram[bus.mem_addr] = bus.mem_wdata;
        end else begin
          bus.mem_rdata = sram[bus.mem_addr];
          last_rd_addr = int'(bus.mem_addr);
        end
        wcnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
      chk("idle_bus_zero", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
    end
  end

  // Result monitor
  always @(negedge clk) begin
    if (!rst && past_valid) begin
      pv_cyc = cyc;
      if (exp_past.size() == 0) fail("past_unexpected");
      else chk("past_output", 32'(past_output), 32'(exp_past.pop_front()));
    end
    if (!rst && overrun) ovr_seen++;
  end

  // Reference model: the delay line is just an array indexed by sample count mod DEPTH
  task automatic send(input logic [7:0] d, input logic s, input int off);
    int   wa, ra, fb;
    logic rd;
    wa = wcount % DEPTH;
    ref_mem[wa] = d;
    exp_acc.push_back('{we: 1'b1, addr: wa, data: d});
    fb = (wcount < DEPTH) ? wcount : DEPTH;
    rd = s;
`ifdef TEAM_06_FILL_GUARD_EN
    if (off > fb) rd = 1'b0;
`endif
    if (rd) begin
      ra = (wa + DEPTH - off) % DEPTH;
      exp_acc.push_back('{we: 1'b0, addr: ra, data: 8'h00});
      exp_past.push_back(ref_mem[ra]);
    end else begin
      exp_past.push_back(8'h00);
    end
    wcount++;
    sample_valid = 1'b1;
    save_audio   = d;
    search       = s;
    offset       = 13'(off);
    issue_cyc    = cyc;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail("idle_timeout");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst = 1'b1;
    sample_valid = 1'b0;
    save_audio = 8'h00;
    search = 1'b0;
    offset = 13'd0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({past_output, past_valid, busy, overrun, bus.mem_req}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a write access
    wait_target = 5;
    sample_valid = 1'b1;
    save_audio = 8'h55;
    search = 1'b1;
    offset = 13'd0;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("midwrite_req", 32'({bus.mem_req, bus.mem_we, busy}), 32'b111);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outputs_zero", 32'({past_output, past_valid, busy, overrun, bus.mem_req, bus.mem_we}), 32'd0);
    chk("rst_bus_zero", 32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic echo, zero-wait SRAM; the first write after reset must land at address 0
    wait_target = 0;
    send(8'd10, 1'b1, 3); wait_idle();
    send(8'd20, 1'b1, 3); wait_idle();
    send(8'd30, 1'b1, 3); wait_idle();
    send(8'd40, 1'b1, 3); wait_idle();
    chk("latency_search", 32'(pv_cyc - issue_cyc), 32'd3);
    send(8'd50, 1'b0, 1); wait_idle();
    chk("latency_nosearch", 32'(pv_cyc - issue_cyc), 32'd2);

    // Three wait states on both accesses
    wait_target = 3;
    send(8'd60, 1'b1, 1); wait_idle();
    chk("latency_wait3", 32'(pv_cyc - issue_cyc), 32'd9);

    // Overrun: second strobe in cycle 1 of the access is dropped
    wait_target = 0;
    send(8'd70, 1'b1, 2);
    sample_valid = 1'b1;
    save_audio = 8'hEE;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("overrun_pulse", 32'(overrun), 32'd1);
    ovr_exp++;
    wait_idle();

    // offset 0 reads back the sample just written
    send(8'hA5, 1'b1, 0); wait_idle();

    // Randomized traffic with random wait states
    rand_wait = 1;
    for (int i = 0; i < 150; i++) begin
      send(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 12)));
      wait_idle();
    end
    rand_wait = 0;

    // Fill past one full lap, then the wrap-around read at wr_addr 5
    while (!(wcount > DEPTH && (wcount % DEPTH) == 5)) begin
      send(8'($urandom), 1'b0, 0);
      wait_idle();
    end
    send(8'($urandom), 1'b1, 8000); wait_idle();
    chk("wrap_read_addr", 32'(last_rd_addr), 32'd197);

    // Maximum offset on a full buffer reaches one past wr_addr
    send(8'($urandom), 1'b1, 8191); wait_idle();
    chk("max_offset_addr", 32'(last_rd_addr), 32'((wcount) % DEPTH));

    repeat (4) @(negedge clk);
    chk("past_queue_drained", 32'(exp_past.size()), 32'd0);
    chk("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
    chk("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/team_06_delay_line_ctrl.md
# team_06_delay_line_ctrl

Sequencer for the echo path's delay-line memory. The block takes each new audio sample, writes it into the shared sample SRAM at a circular write pointer, and optionally reads back the sample `offset` positions earlier. It returns that older sample as `past_output` for the echo mixer. It sits between the echo effect stage and the SRAM, and is the only block that drives the SRAM request port.

## Interface
- `DEPTH`, default 8192: delay-line length in samples; must be a power of two.
- `ADDR_W`, default 13: SRAM address width; `2**ADDR_W == DEPTH`.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `sample_valid` in 1: one-cycle strobe; a new sample is present on `save_audio`.
- `save_audio` in 8: sample to store.
- `search` in 1: past-sample read requested for this sample; sampled with `sample_valid`.
- `offset` in 13: delay in samples; sampled with `sample_valid`.
- `past_output` out 8: retrieved past sample; held until the next DONE.
- `past_valid` out 1: one-cycle pulse; `past_output` is updated.
- `busy` out 1: high in every state except IDLE.
- `overrun` out 1: one-cycle pulse; a `sample_valid` arrived while busy and was dropped.
- `mem_req` out 1: SRAM access request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out ADDR_W: SRAM address.
- `mem_wdata` out 8: write data.
- `mem_rdata` in 8: read data, valid in the `mem_ack` cycle.
- `mem_ack` in 1: access complete; may arrive in the first cycle `mem_req` is high.

## Operation
- FSM states: IDLE, WRITE, READ, DONE.
- **IDLE**
  - On `sample_valid`: latch `save_audio`, `search` and `offset` (clamped to DEPTH-1 if larger).
  - Latch `wr_addr = wr_ptr` and go to WRITE.
- **WRITE**
  - Drive `mem_req=1`, `mem_we=1`, `mem_addr=wr_addr`, `mem_wdata=` latched sample.
  - On `mem_ack`: `wr_ptr <= wr_ptr+1` (mod DEPTH); `fill_count <= min(fill_count+1, DEPTH)`.
  - Then go to READ if the latched search is 1 and the guard passes (see Configuration); otherwise go to DONE.
- **READ**
  - Drive `mem_req=1`, `mem_we=0`, `mem_addr = (wr_addr - offset) mod DEPTH`. This is ADDR_W-bit wrap-around subtraction.
  - On `mem_ack`: capture `mem_rdata` into `past_output` and go to DONE.
- **DONE**
  - Pulse `past_valid` for one cycle, then return to IDLE.
  - If READ was skipped, `past_output` is 0.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable until `mem_ack`. Outside WRITE/READ they are all 0.
- `mem_ack` received outside WRITE/READ is ignored.
- `offset = 0` reads back the sample just written.
- `sample_valid` in any state other than IDLE: the sample is dropped, `overrun` pulses the next cycle, and state is unaffected.
- `rst` (any state, including mid-access): the next state is IDLE.
  - `wr_ptr`, `fill_count`, `past_output`, `past_valid`, `busy`, `overrun` and all `mem_*` outputs are 0 after the edge.
  - An outstanding SRAM access is abandoned.

## Timing
- All outputs are registered from FSM state or latched data. Reset value of every output is 0.
- Zero-wait SRAM (ack in first request cycle), with `sample_valid` at cycle 0:
  - search=1: WRITE in cycle 1, READ in cycle 2, `past_valid` in cycle 3.
  - search=0: `past_valid` in cycle 2.
- Each SRAM wait cycle adds one cycle to that state.
- A new sample is accepted in the cycle after DONE. Minimum sample spacing is 4 cycles with search, 3 without.

## Configuration
- Macro `TEAM_06_FILL_GUARD_EN`.
  - **Defined:** READ is skipped (`past_output=0`) when `offset > fill_count` as it was before this write. Unwritten locations are never read.
  - **Undefined:** READ always occurs when search=1, regardless of `fill_count`. `fill_count` logic may be omitted.

## Test plan
- **Reset:** assert `rst` mid-WRITE with `mem_req` high.
  - Expect all outputs 0 the next cycle and FSM in IDLE.
  - Next sample is written to address 0.
- **Basic echo:** zero-wait SRAM, `offset=3`, samples 10, 20, 30, 40 with search=1.
  - Fourth sample: read address 0 and `past_output=10` in cycle 3.
  - With guard defined, the first three samples give `past_output=0` and no READ request.
- **Wrap-around:** write 8192+5 samples, `offset=8000`, on the sample at `wr_addr=5`.
  - Expect `mem_addr=197` in READ.
  - Expect returned data equal to the sample written at address 197.
- **Wait states:** `mem_ack` delayed 3 cycles on both accesses.
  - Request signals stay stable and `busy` stays high.
  - `past_valid` arrives 9 cycles after `sample_valid`.
- **Overrun:** `sample_valid` again in cycle 1 of an access.
  - Expect an `overrun` pulse in cycle 2.
  - Second sample is not written; `wr_ptr` advances by 1 only.
- **Offset edges:** `offset=0` returns the just-written value. `offset=8191` with `DEPTH=8192` after a full buffer returns the sample written one position after `wr_addr`.
